// File: rtl/vga_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sched_pkg: shared types and constants for the VGA RAM writer  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package vga_sched_pkg;

   typedef enum logic [1:0] {
      REQ_REG   = 2'd0,
      REQ_INSTR = 2'd1,
      REQ_DATA  = 2'd2
   } req_id_e;

   typedef enum logic [0:0] {
      LOCK = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   localparam int MEM_SLOTS = 92;
   localparam int REG_SLOTS = 32;

   // Cyclic successor in REG -> INSTR -> DATA -> REG order.
   function automatic logic [1:0] rr_next(input logic [1:0] id);
      return (id >= 2'd2) ? 2'd0 : id + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_ram_write_sched_rr_arbiter3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter3: combinational 3-way round-robin grant from a pointer |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_arbiter3
   import vga_sched_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] grant,
   output logic [1:0] next_ptr
);

   logic [3:0] w_req4;
   logic [1:0] w_idx;
   logic       w_found;

   assign w_req4 = {1'b0, req};

   always_comb begin
      grant    = 3'b000;
      next_ptr = ptr;
      w_idx    = ptr;
      w_found  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (!w_found && w_req4[w_idx]) begin
            grant    = 3'b001 << w_idx;
            next_ptr = rr_next(w_idx);
            w_found  = 1'b1;
         end
         w_idx = rr_next(w_idx);
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_ram_write_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_ram_write_sched: buffers shadow updates from three requesters |
// | and issues one RAM write per cycle, round-robin, during blanking. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module vga_ram_write_sched #(
   parameter int DATA_W    = 32,
   parameter int REG_SLOTS = vga_sched_pkg::REG_SLOTS,
   parameter int MEM_SLOTS = vga_sched_pkg::MEM_SLOTS,
   parameter int ERR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              blank,
   input  logic              reg_valid,
   output logic              reg_ready,
   input  logic [4:0]        reg_addr,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr_addr,
   input  logic [DATA_W-1:0] instr_data,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [31:0]       data_addr,
   input  logic [DATA_W-1:0] data_data,
   output logic              reg_mem_enable,
   output logic [4:0]        reg_mem_addr,
   output logic [DATA_W-1:0] reg_mem_data,
   output logic              instr_mem_enable,
   output logic [31:0]       instr_mem_addr,
   output logic [DATA_W-1:0] instr_mem_data,
   output logic              data_mem_enable,
   output logic [31:0]       data_mem_addr,
   output logic [DATA_W-1:0] data_mem_data,
   output logic [ERR_W-1:0]  drop_count,
   output logic              busy
);
   import vga_sched_pkg::*;

   localparam logic [0:0] c_ST_LOCK = LOCK;
   localparam logic [0:0] c_ST_RUN  = RUN;

   logic [0:0]        r_state;
   logic [1:0]        r_ptr;
   logic [1:0]        w_next_ptr;
   logic [2:0]        w_req;
   logic [2:0]        w_grant;
   logic              w_run;

   logic              r_reg_full, r_instr_full, r_data_full;
   logic [4:0]        r_reg_addr;
   logic [31:0]       r_instr_addr, r_data_addr;
   logic [DATA_W-1:0] r_reg_data, r_instr_data, r_data_data;

   logic              w_reg_acc, w_instr_acc, w_data_acc;
   logic              w_reg_ok, w_instr_ok, w_data_ok;
   logic              w_instr_drop, w_data_drop;
   logic [ERR_W:0]    w_drop_sum;

   // Grants only from the registered RUN state while blanking is still active.
   assign w_run = (r_state == c_ST_RUN) && blank;
   assign w_req = {r_data_full, r_instr_full, r_reg_full} & {3{w_run}};

   rr_arbiter3 u_arb (
      .req      (w_req),
      .ptr      (r_ptr),
      .grant    (w_grant),
      .next_ptr (w_next_ptr)
   );

   assign reg_ready   = !r_reg_full   || w_grant[REQ_REG];
   assign instr_ready = !r_instr_full || w_grant[REQ_INSTR];
   assign data_ready  = !r_data_full  || w_grant[REQ_DATA];

   assign w_reg_acc   = reg_valid   && reg_ready;
   assign w_instr_acc = instr_valid && instr_ready;
   assign w_data_acc  = data_valid  && data_ready;

   assign w_reg_ok    = 32'(reg_addr) < 32'(REG_SLOTS);
   assign w_instr_ok  = instr_addr < 32'(MEM_SLOTS);
   assign w_data_ok   = data_addr  < 32'(MEM_SLOTS);

   assign w_instr_drop = w_instr_acc && !w_instr_ok;
   assign w_data_drop  = w_data_acc  && !w_data_ok;
   assign w_drop_sum   = {1'b0, drop_count} + {{ERR_W{1'b0}}, w_instr_drop}
                                            + {{ERR_W{1'b0}}, w_data_drop};

   assign busy = r_reg_full || r_instr_full || r_data_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_ST_LOCK;
         r_ptr   <= REQ_REG;
      end else begin
         case (r_state)
            c_ST_LOCK: if (blank)  r_state <= c_ST_RUN;
            default:   if (!blank) r_state <= c_ST_LOCK;
         endcase
         r_ptr <= w_next_ptr;
      end
   end

   // A refill in the grant cycle takes priority over clearing the full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reg_full   <= 1'b0;
         r_instr_full <= 1'b0;
         r_data_full  <= 1'b0;
         r_reg_addr   <= '0;
         r_instr_addr <= '0;
         r_data_addr  <= '0;
         r_reg_data   <= '0;
         r_instr_data <= '0;
         r_data_data  <= '0;
      end else begin
         if (w_reg_acc && w_reg_ok) begin
            r_reg_full <= 1'b1;
            r_reg_addr <= reg_addr;
            r_reg_data <= reg_data;
         end else if (w_grant[REQ_REG]) begin
            r_reg_full <= 1'b0;
         end
         if (w_instr_acc && w_instr_ok) begin
            r_instr_full <= 1'b1;
            r_instr_addr <= instr_addr;
            r_instr_data <= instr_data;
         end else if (w_grant[REQ_INSTR]) begin
            r_instr_full <= 1'b0;
         end
         if (w_data_acc && w_data_ok) begin
            r_data_full <= 1'b1;
            r_data_addr <= data_addr;
            r_data_data <= data_data;
         end else if (w_grant[REQ_DATA]) begin
            r_data_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_mem_enable   <= 1'b0;
         instr_mem_enable <= 1'b0;
         data_mem_enable  <= 1'b0;
         reg_mem_addr     <= '0;
         reg_mem_data     <= '0;
         instr_mem_addr   <= '0;
         instr_mem_data   <= '0;
         data_mem_addr    <= '0;
         data_mem_data    <= '0;
         drop_count       <= '0;
      end else begin
         reg_mem_enable   <= w_grant[REQ_REG];
         instr_mem_enable <= w_grant[REQ_INSTR];
         data_mem_enable  <= w_grant[REQ_DATA];
         if (w_grant[REQ_REG]) begin
            reg_mem_addr <= r_reg_addr;
            reg_mem_data <= r_reg_data;
         end
         if (w_grant[REQ_INSTR]) begin
            instr_mem_addr <= r_instr_addr;
            instr_mem_data <= r_instr_data;
         end
         if (w_grant[REQ_DATA]) begin
            data_mem_addr <= r_data_addr;
            data_mem_data <= r_data_data;
         end
         drop_count <= w_drop_sum[ERR_W] ? {ERR_W{1'b1}} : w_drop_sum[ERR_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_ram_write_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_ram_write_sched: directed bench with a cycle-level model   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_vga_ram_write_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        blank = 1'b0;
   logic        reg_valid = 1'b0, instr_valid = 1'b0, data_valid = 1'b0;
   logic [4:0]  reg_addr = '0;
   logic [31:0] reg_data = '0, instr_addr = '0, instr_data = '0, data_addr = '0, data_data = '0;
   logic        reg_ready, instr_ready, data_ready;
   logic        reg_mem_enable, instr_mem_enable, data_mem_enable;
   logic [4:0]  reg_mem_addr;
   logic [31:0] reg_mem_data, instr_mem_addr, instr_mem_data, data_mem_addr, data_mem_data;
   logic [7:0]  drop_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vga_ram_write_sched dut (
      .clk(clk), .rst(rst), .blank(blank),
      .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_addr(reg_addr), .reg_data(reg_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_addr(instr_addr), .instr_data(instr_data),
      .data_valid(data_valid), .data_ready(data_ready), .data_addr(data_addr), .data_data(data_data),
      .reg_mem_enable(reg_mem_enable), .reg_mem_addr(reg_mem_addr), .reg_mem_data(reg_mem_data),
      .instr_mem_enable(instr_mem_enable), .instr_mem_addr(instr_mem_addr), .instr_mem_data(instr_mem_data),
      .data_mem_enable(data_mem_enable), .data_mem_addr(data_mem_addr), .data_mem_data(data_mem_data),
      .drop_count(drop_count), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one pending slot per requester, a RUN flag and a rotating start index.
   bit          m_full [3];
   logic [31:0] m_addr [3];
   logic [31:0] m_data [3];
   bit          m_run;
   int          m_ptr;
   int          m_drops;
   bit          e_en   [3];
   logic [31:0] e_addr [3];
   logic [31:0] e_data [3];

   always @(negedge clk) begin
      int          g;
      bit          rdy [3];
      bit          vld [3];
      logic [31:0] ia  [3];
      logic [31:0] id  [3];
      if (rst) begin
         for (int x = 0; x < 3; x++) begin
            m_full[x] = 0; e_en[x] = 0; e_addr[x] = '0; e_data[x] = '0;
         end
         m_run = 0; m_ptr = 0; m_drops = 0;
      end
      chk("reg_mem_enable",   reg_mem_enable,   e_en[0]);
      chk("reg_mem_addr",     reg_mem_addr,     e_addr[0][4:0]);
      chk("reg_mem_data",     reg_mem_data,     e_data[0]);
      chk("instr_mem_enable", instr_mem_enable, e_en[1]);
      chk("instr_mem_addr",   instr_mem_addr,   e_addr[1]);
      chk("instr_mem_data",   instr_mem_data,   e_data[1]);
      chk("data_mem_enable",  data_mem_enable,  e_en[2]);
      chk("data_mem_addr",    data_mem_addr,    e_addr[2]);
      chk("data_mem_data",    data_mem_data,    e_data[2]);
      chk("drop_count",       drop_count,       (m_drops > 255) ? 255 : m_drops);
      chk("busy",             busy,             m_full[0] | m_full[1] | m_full[2]);
      if (!rst) begin
         g = -1;
         if (m_run && blank)
            for (int k = 0; k < 3; k++)
               if (g < 0 && m_full[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
         for (int x = 0; x < 3; x++) rdy[x] = !m_full[x] || (g == x);
         chk("reg_ready",   reg_ready,   rdy[0]);
         chk("instr_ready", instr_ready, rdy[1]);
         chk("data_ready",  data_ready,  rdy[2]);
         vld[0] = reg_valid;   ia[0] = {27'd0, reg_addr}; id[0] = reg_data;
         vld[1] = instr_valid; ia[1] = instr_addr;        id[1] = instr_data;
         vld[2] = data_valid;  ia[2] = data_addr;         id[2] = data_data;
         for (int x = 0; x < 3; x++) e_en[x] = 0;
         if (g >= 0) begin
            e_en[g] = 1; e_addr[g] = m_addr[g]; e_data[g] = m_data[g];
            m_full[g] = 0; m_ptr = (g + 1) % 3;
         end
         for (int x = 0; x < 3; x++)
            if (vld[x] && rdy[x]) begin
               if (x == 0 || ia[x] < 92) begin
                  m_full[x] = 1; m_addr[x] = ia[x]; m_data[x] = id[x];
               end else begin
                  m_drops++;
               end
            end
         m_run = blank;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int n_en();
      return int'(reg_mem_enable) + int'(instr_mem_enable) + int'(data_mem_enable);
   endfunction

   initial begin
      int n_reg, n_ins, n_dat, n_bad, total;
      blank = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // Single register write: accept at N, enable at N+2
      reg_valid = 1; reg_addr = 5'd5; reg_data = 32'hDEADBEEF;
      chk("t1_reg_ready", reg_ready, 1);
      tick();
      reg_valid = 0;
      chk("t1_no_en_n1", n_en(), 0);
      chk("t1_busy_n1", busy, 1);
      tick();
      chk("t1_reg_en", reg_mem_enable, 1);
      chk("t1_reg_addr", reg_mem_addr, 5);
      chk("t1_reg_data", reg_mem_data, 32'hDEADBEEF);
      chk("t1_only_one", n_en(), 1);
      tick();
      chk("t1_reg_en_off", reg_mem_enable, 0);
      chk("t1_busy_off", busy, 0);

      // Posting while not blanking, then release
      blank = 0;
      repeat (2) tick();
      instr_valid = 1; instr_addr = 3;  instr_data = 32'h13;
      data_valid  = 1; data_addr  = 50; data_data  = 32'hCAFE;
      tick();
      instr_valid = 0; data_valid = 0;
      chk("t2_instr_ready", instr_ready, 0);
      chk("t2_data_ready", data_ready, 0);
      for (int c = 0; c < 3; c++) begin
         chk("t2_no_en_locked", n_en(), 0);
         tick();
      end
      blank = 1;
      tick();
      chk("t2_no_en_first_run", n_en(), 0);
      tick();
      chk("t2_instr_en", instr_mem_enable, 1);
      chk("t2_instr_addr", instr_mem_addr, 3);
      chk("t2_instr_data", instr_mem_data, 32'h13);
      chk("t2_data_en_early", data_mem_enable, 0);
      tick();
      chk("t2_data_en", data_mem_enable, 1);
      chk("t2_data_addr", data_mem_addr, 50);
      chk("t2_data_data", data_mem_data, 32'hCAFE);
      chk("t2_instr_en_off", instr_mem_enable, 0);
      tick();
      chk("t2_busy_off", busy, 0);

      // All three requesters continuously valid
      n_reg = 0; n_ins = 0; n_dat = 0; n_bad = 0;
      reg_valid = 1; instr_valid = 1; data_valid = 1;
      for (int c = 0; c < 14; c++) begin
         reg_addr = 5'(c); reg_data = 32'h1000 + c;
         instr_addr = c % 92; instr_data = 32'h2000 + c;
         data_addr = (c + 7) % 92; data_data = 32'h3000 + c;
         if (c == 2) chk("t3_first_is_reg", reg_mem_enable, 1);
         if (c >= 2 && c < 11) begin
            n_reg += int'(reg_mem_enable);
            n_ins += int'(instr_mem_enable);
            n_dat += int'(data_mem_enable);
            if (n_en() != 1) n_bad++;
         end
         tick();
      end
      reg_valid = 0; instr_valid = 0; data_valid = 0;
      chk("t3_reg_writes", n_reg, 3);
      chk("t3_instr_writes", n_ins, 3);
      chk("t3_data_writes", n_dat, 3);
      chk("t3_not_one_hot", n_bad, 0);
      repeat (6) tick();
      chk("t3_drained", busy, 0);

      // Out-of-range requests and counter saturation
      instr_valid = 1; instr_addr = 92;  instr_data = 32'h1;
      data_valid  = 1; data_addr  = 200; data_data  = 32'h2;
      tick();
      instr_valid = 0; data_valid = 0;
      chk("t4_drop_two", drop_count, 2);
      for (int c = 0; c < 3; c++) begin
         chk("t4_no_en", n_en(), 0);
         tick();
      end
      chk("t4_not_busy", busy, 0);
      instr_valid = 1; data_valid = 1;
      repeat (130) tick();
      instr_valid = 0; data_valid = 0;
      chk("t4_drop_sat", drop_count, 255);
      instr_valid = 1;
      tick();
      instr_valid = 0;
      chk("t4_drop_stays", drop_count, 255);

      // Blank drops after the first grant
      blank = 0;
      repeat (2) tick();
      reg_valid = 1; instr_valid = 1; data_valid = 1;
      reg_addr = 9; instr_addr = 10; data_addr = 11;
      tick();
      reg_valid = 0; instr_valid = 0; data_valid = 0;
      chk("t5_busy_loaded", busy, 1);
      blank = 1;
      tick();
      tick();
      blank = 0;
      total = 0;
      for (int c = 0; c < 5; c++) begin
         total += n_en();
         tick();
      end
      chk("t5_one_write", total, 1);
      chk("t5_still_busy", busy, 1);
      chk("t5_two_pending", int'(!reg_ready) + int'(!instr_ready) + int'(!data_ready), 2);

      // Asynchronous reset in the middle of a burst
      blank = 1;
      tick();
      tick();
      chk("t6_write_in_flight", n_en(), 1);
      #2 rst = 1;
      #1;
      chk("t6_en_cleared", n_en(), 0);
      chk("t6_busy_cleared", busy, 0);
      tick();
      rst = 0;
      total = 0;
      for (int c = 0; c < 5; c++) begin
         total += n_en();
         tick();
      end
      chk("t6_no_stale_writes", total, 0);
      chk("t6_busy_after", busy, 0);
      chk("t6_drop_cleared", drop_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
